// File: rtl/demux_1_8_v_behavior_if.sv
// Bus bundle for the registered 1-to-8 demultiplexer: data bit and select in,
// decoded line bus and select-error flag out.
interface demux_1_8_v_behavior_if;
  logic       i_a;
  logic [7:0] i_sel_code;
  logic [7:0] o_code;
  logic       o_sel_err;

  modport master (
    output i_a,
    output i_sel_code,
    input  o_code,
    input  o_sel_err
  );

  modport slave (
    input  i_a,
    input  i_sel_code,
    output o_code,
    output o_sel_err
  );
endinterface

// File: rtl/demux_1_8_v_behavior.sv
// Registered 1-to-8 demux: i_a lands on line i_sel_code[2:0], every other line is low.
// Define DEMUX_SEL_CHECK_EN to flag non-zero reserved select bits and blank the bus.

module demux_1_8_v_behavior_lane #(
  parameter int IDX = 0
) (
  input  logic       a,
  input  logic [2:0] idx,
  input  logic       blank,
  output logic       d
);
  assign d = a & ~blank & (idx == IDX[2:0]);
endmodule

module demux_1_8_v_behavior (
  input  logic                        i_clk,
  input  logic                        i_rst,
  demux_1_8_v_behavior_if.slave       bus
);
  localparam int NUM_LANES = 8;

  logic [2:0]           idx;
  logic                 sel_err_nxt;
  logic [NUM_LANES-1:0] code_nxt;

  assign idx = bus.i_sel_code[2:0];

`ifdef DEMUX_SEL_CHECK_EN
  assign sel_err_nxt = |bus.i_sel_code[7:3];
`else
  // Reserved bits are ignored; keep them referenced so they read as intentionally unused.
  logic unused_rsvd;
  assign unused_rsvd = ^bus.i_sel_code[7:3];
  assign sel_err_nxt = 1'b0;
`endif

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    demux_1_8_v_behavior_lane #(.IDX(g)) u_lane (
      .a     (bus.i_a),
      .idx   (idx),
      .blank (sel_err_nxt),
      .d     (code_nxt[g])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bus.o_code    <= '0;
      bus.o_sel_err <= 1'b0;
    end else begin
      bus.o_code    <= code_nxt;
      bus.o_sel_err <= sel_err_nxt;
    end
  end
endmodule

// File: tb/tb_demux_1_8_v_behavior.sv
// Scoreboard bench for demux_1_8_v_behavior; expectations come from a reference model
// that follows the build's DEMUX_SEL_CHECK_EN setting.
module tb_demux_1_8_v_behavior;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;

  demux_1_8_v_behavior_if bus ();

  demux_1_8_v_behavior dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] code;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic exp_t model(input logic rst, input logic a, input logic [7:0] sel);
    exp_t e;
    e.code = 8'h00;
    e.err  = 1'b0;
    if (!rst) begin
`ifdef DEMUX_SEL_CHECK_EN
      if (sel[7:3] != 5'd0) e.err = 1'b1;
`endif
      if (!e.err && a) e.code = 8'h01 << sel[2:0];
    end
    return e;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, step past the edge.
  task automatic drive_cycle(input logic rst, input logic a, input logic [7:0] sel);
    i_rst          = rst;
    bus.i_a        = a;
    bus.i_sel_code = sel;
    exp_q.push_back(model(rst, a, sel));
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      drive_cycle(1'b1, 1'b1, 8'h03);
      e = exp_q.pop_front();
      total++;
      if (bus.o_code !== e.code || bus.o_sel_err !== e.err || e.code !== 8'h00) begin
        bad++;
        $display("FAIL reset[%0d] got code=%h err=%b want code=00 err=0", k, bus.o_code, bus.o_sel_err);
      end
    end
  endtask

  task automatic test_sweep();
    exp_t e;
    for (int s = 0; s < 8; s++) begin
      logic [7:0] sv = s[7:0];
      logic [7:0] want = 8'h01 << s;
      drive_cycle(1'b0, 1'b1, sv);
      e = exp_q.pop_front();
      total++;
      if (bus.o_code !== want || bus.o_code !== e.code || bus.o_sel_err !== 1'b0) begin
        bad++;
        $display("FAIL sweep[%0d] got code=%h err=%b want code=%h err=0", s, bus.o_code, bus.o_sel_err, want);
      end
    end
  endtask

  task automatic test_zero_data();
    exp_t e;
    drive_cycle(1'b0, 1'b0, 8'h05);
    e = exp_q.pop_front();
    total++;
    if (bus.o_code !== 8'h00 || bus.o_code !== e.code) begin
      bad++;
      $display("FAIL zero_data got code=%h want code=00", bus.o_code);
    end
    drive_cycle(1'b0, 1'b1, 8'h05);
    e = exp_q.pop_front();
    total++;
    if (bus.o_code !== 8'h20 || bus.o_code !== e.code) begin
      bad++;
      $display("FAIL zero_data_then_one got code=%h want code=20", bus.o_code);
    end
  endtask

  task automatic test_reserved();
    exp_t e;
    logic [7:0] want_code;
    logic       want_err;
`ifdef DEMUX_SEL_CHECK_EN
    want_code = 8'h00;
    want_err  = 1'b1;
`else
    want_code = 8'h02;
    want_err  = 1'b0;
`endif
    drive_cycle(1'b0, 1'b1, 8'h09);
    e = exp_q.pop_front();
    total++;
    if (bus.o_code !== want_code || bus.o_sel_err !== want_err || e.code !== want_code) begin
      bad++;
      $display("FAIL reserved got code=%h err=%b want code=%h err=%b",
               bus.o_code, bus.o_sel_err, want_code, want_err);
    end
    // Flag must clear as soon as the reserved bits do.
    drive_cycle(1'b0, 1'b1, 8'h01);
    e = exp_q.pop_front();
    total++;
    if (bus.o_code !== 8'h02 || bus.o_sel_err !== 1'b0) begin
      bad++;
      $display("FAIL reserved_clear got code=%h err=%b want code=02 err=0", bus.o_code, bus.o_sel_err);
    end
  endtask

  task automatic test_exhaustive();
    exp_t e;
    for (int d = 0; d < 256; d++) begin
      logic [7:0] dv = d[7:0];
      drive_cycle(1'b0, dv[0], dv);
      e = exp_q.pop_front();
      total++;
      if (bus.o_code !== e.code || bus.o_sel_err !== e.err) begin
        bad++;
        $display("FAIL exhaustive[%0d] got code=%h err=%b want code=%h err=%b",
                 d, bus.o_code, bus.o_sel_err, e.code, e.err);
      end
    end
  endtask

  task automatic test_hold();
    exp_t e;
    drive_cycle(1'b0, 1'b1, 8'h06);
    e = exp_q.pop_front();
    // Change inputs away from the edge; outputs must not move until the next edge.
    bus.i_a        = 1'b0;
    bus.i_sel_code = 8'h01;
    #2;
    total++;
    if (bus.o_code !== 8'h40 || bus.o_code !== e.code) begin
      bad++;
      $display("FAIL hold got code=%h want code=40", bus.o_code);
    end
    bus.i_a        = 1'b1;
    bus.i_sel_code = 8'h06;
  endtask

  task automatic test_mid_reset();
    exp_t e;
    drive_cycle(1'b0, 1'b1, 8'h04);
    e = exp_q.pop_front();
    total++;
    if (bus.o_code !== 8'h10 || bus.o_code !== e.code) begin
      bad++;
      $display("FAIL mid_reset_pre got code=%h want code=10", bus.o_code);
    end
    drive_cycle(1'b1, 1'b1, 8'h04);
    e = exp_q.pop_front();
    total++;
    if (bus.o_code !== 8'h00 || bus.o_sel_err !== 1'b0 || e.code !== 8'h00) begin
      bad++;
      $display("FAIL mid_reset got code=%h err=%b want code=00 err=0", bus.o_code, bus.o_sel_err);
    end
    drive_cycle(1'b0, 1'b1, 8'h04);
    e = exp_q.pop_front();
    total++;
    if (bus.o_code !== 8'h10 || bus.o_code !== e.code) begin
      bad++;
      $display("FAIL mid_reset_release got code=%h want code=10", bus.o_code);
    end
  endtask

  initial begin
    bus.i_a        = 1'b0;
    bus.i_sel_code = 8'h00;
    #2;
    test_reset();
    test_sweep();
    test_zero_data();
    test_reserved();
    test_exhaustive();
    test_hold();
    test_mid_reset();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got %0d leftover want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
